// File: rtl/stack_cmd_ctrl_if.sv
// Button, operand and stack-command signals between the pushbutton panel and
// the stack controller.
interface stack_cmd_ctrl_if;
   logic       b_push;
   logic       b_pop;
   logic       b_exch;
   logic [3:0] sw;
   logic [2:0] depth;
   logic       w1;
   logic       w2;
   logic       w3;
   logic [3:0] dout;
   logic       busy;
   logic       err;
   logic [7:0] cmd_cnt;

   modport master (
      output b_push, b_pop, b_exch, sw, depth,
      input  w1, w2, w3, dout, busy, err, cmd_cnt
   );

   modport slave (
      input  b_push, b_pop, b_exch, sw, depth,
      output w1, w2, w3, dout, busy, err, cmd_cnt
   );
endinterface

// File: rtl/stack_cmd_ctrl.sv
// Pushbutton front end for a 4-deep stack: synchronizes and debounces three
// buttons, then issues one push/pop/exchange pulse per press.
module stack_cmd_ctrl #(
   parameter int unsigned DB_CYCLES = 4
) (
   input logic             ctl,
   input logic             rst,
   stack_cmd_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
   typedef enum logic [1:0] {CMD_PUSH, CMD_POP, CMD_EXCH} cmd_t;

   // Bit order everywhere: [0] push, [1] pop, [2] exch.
   logic [2:0]    s1_q, s2_q, db_q, dbp_q;
   logic [CW-1:0] cnt_q [3];
   logic [2:0]    press;
   logic [2:0]    depth_sat;

   state_t     state_q;
   cmd_t       cmd_q;
   logic       w1_q, w2_q, w3_q, busy_q, err_q;
   logic [3:0] dout_q;
   logic [7:0] cmd_cnt_q;

   always_ff @(posedge ctl) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         db_q  <= '0;
         dbp_q <= '0;
         for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         s1_q  <= {bus.b_exch, bus.b_pop, bus.b_push};
         s2_q  <= s1_q;
         dbp_q <= db_q;
         for (int unsigned i = 0; i < 3; i++) begin
            if (s2_q[i] != db_q[i]) begin
               if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                  db_q[i]  <= s2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + CW'(1);
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign press     = db_q & ~dbp_q;
   assign depth_sat = (bus.depth > 3'd4) ? 3'd4 : bus.depth;

   // Pulses are registered at the edge that ends ISSUE, so depth is taken in
   // the ISSUE cycle and a reset on that edge swallows the pulse.
   always_ff @(posedge ctl) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= CMD_PUSH;
         w1_q      <= 1'b0;
         w2_q      <= 1'b0;
         w3_q      <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         dout_q    <= '0;
         cmd_cnt_q <= '0;
      end else begin
         w1_q      <= 1'b0;
         w2_q      <= 1'b0;
         w3_q      <= 1'b0;
         cmd_cnt_q <= cmd_cnt_q + {7'd0, (w1_q | w2_q | w3_q)};
         case (state_q)
            IDLE: begin
               if (|press) begin
                  dout_q  <= bus.sw;
                  cmd_q   <= press[0] ? CMD_PUSH : (press[1] ? CMD_POP : CMD_EXCH);
                  state_q <= ISSUE;
                  busy_q  <= 1'b1;
               end
            end
            ISSUE: begin
               state_q <= HOLD;
               case (cmd_q)
                  CMD_PUSH: if (depth_sat == 3'd4) err_q <= 1'b1; else w2_q <= 1'b1;
                  CMD_POP:  if (depth_sat == 3'd0) err_q <= 1'b1; else w1_q <= 1'b1;
                  default:  if (depth_sat < 3'd2)  err_q <= 1'b1; else w3_q <= 1'b1;
               endcase
            end
            HOLD: begin
               if (db_q == 3'b000) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.w1      = w1_q;
   assign bus.w2      = w2_q;
   assign bus.w3      = w3_q;
   assign bus.dout    = dout_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;
   assign bus.cmd_cnt = cmd_cnt_q;
endmodule
